mac_result_accumulator: RTL

Downstream consumer of the DSP resource manager's result port. It accumulates signed MAC results per virtual-MAC ID over a programmable number of terms. On the final term it requantizes the sum to WIDTH-bit fixed point with rounding and saturation, then queues the value in a small output FIFO with a valid/ready handshake toward the activation/writeback stage. This turns the shared DSP pool's single-term results back into complete per-channel dot products.

---
 rtl/mac_result_accumulator.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mac_result_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : mac_result_accumulator
// Purpose : Per-slot accumulation of signed MAC results into complete dot
//           products, requantized with rounding/saturation into an output FIFO.
// Revision: 1.0
// ============================================================================
module mac_result_accumulator #(
    parameter int WIDTH            = 16,
    parameter int FRAC             = 8,
    parameter int NUM_VIRTUAL_MACS = 32,
    parameter int ACC_WIDTH        = 40,
    parameter int FIFO_DEPTH       = 4,
    localparam int IDW             = $clog2(NUM_VIRTUAL_MACS),
    localparam int CNTW            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic [7:0]           acc_len,
    input  logic [2*WIDTH-1:0]   mac_result,
    input  logic                 mac_valid,
    input  logic [IDW-1:0]       result_id,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNTW-1:0]      fifo_count,
    output logic                 drop_err
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int AW1  = ACC_WIDTH + 1;

    localparam logic signed [AW1-1:0] RND_K   = AW1'(1) << (FRAC - 1);
    localparam logic signed [AW1-1:0] SAT_MAX = AW1'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [AW1-1:0] SAT_MIN = -SAT_MAX - AW1'(1);

    // ------------------------------------------------------------------------
    // Accumulator / term-counter slots
    // ------------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] acc_q [NUM_VIRTUAL_MACS];
    logic        [7:0]           cnt_q [NUM_VIRTUAL_MACS];

    logic                        accept;
    logic        [7:0]           len_eff;
    logic        [8:0]           cnt_inc;
    logic                        is_final;
    logic signed [2*WIDTH-1:0]   res_s;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] acc_wr_d;
    logic        [7:0]           cnt_wr_d;

    always_comb begin
        accept   = mac_valid && en && !clear;
        len_eff  = (acc_len == 8'd0) ? 8'd1 : acc_len;
        cnt_inc  = {1'b0, cnt_q[result_id]} + 9'd1;
        is_final = (cnt_inc >= {1'b0, len_eff});
        res_s    = mac_result;
        sum      = acc_q[result_id] + ACC_WIDTH'(res_s);
        acc_wr_d = is_final ? '0 : sum;
        cnt_wr_d = is_final ? 8'd0 : cnt_inc[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_VIRTUAL_MACS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_VIRTUAL_MACS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (accept) begin
            acc_q[result_id] <= acc_wr_d;
            cnt_q[result_id] <= cnt_wr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Requant stage: holds the completed sum for one cycle
    // ------------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] stage_sum_q;
    logic        [IDW-1:0]       stage_id_q;
    logic                        stage_valid_q;
    logic                        stage_valid_d;

    assign stage_valid_d = accept && is_final;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_sum_q   <= '0;
            stage_id_q    <= '0;
            stage_valid_q <= 1'b0;
        end else if (clear) begin
            stage_valid_q <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            if (stage_valid_d) begin
                stage_sum_q <= sum;
                stage_id_q  <= result_id;
            end
        end
    end

    // One guard bit keeps the rounding add from wrapping at the extremes.
    logic signed [AW1-1:0] rnd;
    logic signed [AW1-1:0] shifted;
    logic        [WIDTH-1:0] req_data;

    always_comb begin
        rnd     = AW1'(stage_sum_q) + RND_K;
        shifted = rnd >>> FRAC;
        if (shifted > SAT_MAX) begin
            req_data = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            req_data = SAT_MIN[WIDTH-1:0];
        end else begin
            req_data = shifted[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_data_q [FIFO_DEPTH];
    logic [IDW-1:0]   mem_id_q   [FIFO_DEPTH];
    logic [PTRW-1:0]  wr_ptr_q;
    logic [PTRW-1:0]  rd_ptr_q;
    logic [CNTW-1:0]  count_q;
    logic [CNTW-1:0]  count_d;
    logic             drop_q;
    logic             drop_d;
    logic             full;
    logic             pop;
    logic             push;

    always_comb begin
        full   = (count_q == CNTW'(FIFO_DEPTH));
        pop    = (count_q != '0) && out_ready;
        // A full FIFO still accepts the push when the head leaves this cycle.
        push   = stage_valid_q && (!full || pop);
        drop_d = drop_q | (stage_valid_q && full && !pop);
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_id_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= req_data;
                mem_id_q[wr_ptr_q]   <= stage_id_q;
                wr_ptr_q             <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTRW'(1);
            end
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = mem_data_q[rd_ptr_q];
    assign out_id     = mem_id_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign drop_err   = drop_q;

endmodule
`default_nettype wire
